// File: rtl/ssd_pkg.sv
// Shared types and segment patterns for the seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t SEG_LUT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational BCD to active-low segment decode; codes 10..15 are dark.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_LUT[i_bcd];
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digits.
// Optional macro LEAD_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_done
);

  localparam int CNT_W      = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SHOW_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // With no blank time every slot starts directly in SHOW.
  localparam scan_state_e SLOT_START = (BLANK_TICKS == 0) ? SHOW : BLANK;

  scan_state_e             r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  seg_t                    r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  scan_state_e             w_state_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_xfer;
  logic                    w_fd_next;
  logic [4*NUM_DIGITS-1:0] w_act_digits_next;
  logic [NUM_DIGITS-1:0]   w_act_dp_next;
  logic [3:0]              w_digit_sel;
  logic [3:0]              w_code;
  seg_t                    w_seg_dec;
  logic                    w_lit;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt + 1'b1;
    w_xfer       = 1'b0;
    w_fd_next    = 1'b0;
    if (!en) begin
      w_state_next = IDLE;
      w_idx_next   = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = SLOT_START;
          w_idx_next   = '0;
          w_cnt_next   = '0;
          w_xfer       = 1'b1;
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_next = SHOW;
            w_cnt_next   = '0;
          end
        end
        SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_next = SLOT_START;
            w_cnt_next   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_next = '0;
              w_xfer     = 1'b1;
              w_fd_next  = 1'b1;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they move with state/index.
  assign w_act_digits_next = w_xfer ? r_pend_digits : r_act_digits;
  assign w_act_dp_next     = w_xfer ? r_pend_dp     : r_act_dp;
  assign w_digit_sel       = w_act_digits_next[4*w_idx_next +: 4];
  assign w_lit             = (w_state_next == SHOW);

`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lead_zero;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_lead_zero[gi] = (w_act_digits_next[4*gi +: 4] == 4'd0);
      end else begin : g_rest
        assign w_lead_zero[gi] = w_lead_zero[gi+1] && (w_act_digits_next[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  assign w_code = (w_lead_zero[w_idx_next] && (w_idx_next != '0)) ? 4'hF : w_digit_sel;
`else
  assign w_code = w_digit_sel;
`endif

  ssd_seg_decode u_seg_decode (
    .i_bcd (w_code),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_frame_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_act_digits <= w_act_digits_next;
      r_act_dp     <= w_act_dp_next;
      r_frame_done <= w_fd_next;
      if (load) begin
        r_pend_digits <= digits;
        r_pend_dp     <= dp_in;
      end
      if (w_lit) begin
        r_an  <= ~(NUM_DIGITS'(1) << w_idx_next);
        r_seg <= w_seg_dec;
        r_dp  <= ~w_act_dp_next[w_idx_next];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign AN         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench: a slot/frame arithmetic model predicts every cycle for two
// instances (blank time 1 and blank time 0) and monitors compare on the falling edge.
module tb_ssd_scan_ctrl;

  localparam int N   = 4;
  localparam int TPD = 4;
  localparam int BLK = 1;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in  = '0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [3:0] an_a, an_b;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BLK)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .load(load),
    .seg(seg_a), .dp(dp_a), .AN(an_a), .frame_done(fd_a)
  );

  ssd_scan_ctrl #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(TPD), .BLANK_TICKS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .load(load),
    .seg(seg_b), .dp(dp_b), .AN(an_b), .frame_done(fd_b)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;

  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  bit          m_run;
  int          m_t;
  bit          m_fd;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, got, want);
    end
  endtask

  function automatic logic [6:0] bcd_pattern(input logic [3:0] code);
    case (code)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] act, input int slot);
    bit lz = 1'b1;
    for (int j = N - 1; j >= slot; j--) begin
      if (act[4*j +: 4] != 4'd0) lz = 1'b0;
    end
`ifdef LEAD_ZERO_BLANK_EN
    if (slot != 0 && lz) return 7'b1111111;
`endif
    return bcd_pattern(act[4*slot +: 4]);
  endfunction

  function automatic exp_t ref_out(input int blank);
    exp_t e;
    int   slot  = (m_t / TPD) % N;
    bit   lit   = m_run && ((m_t % TPD) >= blank);
    e.an  = lit ? ~(4'b0001 << slot) : 4'b1111;
    e.seg = lit ? ref_seg(m_act, slot) : 7'b1111111;
    e.dp  = lit ? ~m_adp[slot] : 1'b1;
    e.fd  = m_fd;
    return e;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    m_run = 1'b0; m_t = 0; m_fd = 1'b0;
  endtask

  // One clock edge: update the model with the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_fd = 1'b0;
      if (!en) begin
        m_run = 1'b0;
        m_t   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
        m_act = m_pend;
        m_adp = m_pdp;
      end else begin
        m_t++;
        if (m_t % (N * TPD) == 0) begin
          m_fd  = 1'b1;
          m_act = m_pend;
          m_adp = m_pdp;
        end
      end
      if (load) begin
        m_pend = digits;
        m_pdp  = dp_in;
      end
    end
    q_a.push_back(ref_out(BLK));
    q_b.push_back(ref_out(0));
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    digits = d;
    dp_in  = p;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    for (int k = 0; k < 100; k++) begin
      if (m_run && ((m_t / TPD) % N) == s) return;
      step();
    end
    tests++;
    fails++;
    $display("FAIL wait_slot %0d: timed out, required reaching slot", s);
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 100; k++) begin
      step();
      if (m_fd) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_frame: timed out, required frame boundary");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("an_a", 32'(an_a), 32'(e.an));
      check("seg_a", 32'(seg_a), 32'(e.seg));
      check("dp_a", 32'(dp_a), 32'(e.dp));
      check("fd_a", 32'(fd_a), 32'(e.fd));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("an_b", 32'(an_b), 32'(e.an));
      check("seg_b", 32'(seg_b), 32'(e.seg));
      check("dp_b", 32'(dp_b), 32'(e.dp));
      check("fd_b", 32'(fd_b), 32'(e.fd));
    end
  end

  initial begin
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(3);

    pulse_load(16'h1234, 4'b0100);
    en = 1'b1;
    run(36);

    wait_slot(1);
    pulse_load(16'h5678, 4'b0000);
    run(40);

    pulse_load(16'h00AF, 4'b0011);
    wait_frame();
    wait_slot(2);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(20);

    pulse_load(16'h0050, 4'b0001);
    wait_frame();
    run(20);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 5) == 0) begin
        digits = 16'($urandom);
        dp_in  = 4'($urandom);
        load   = 1'b1;
      end else begin
        load   = 1'b0;
      end
      step();
    end
    load = 1'b0;

    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (ref_out(BLK).an != 4'b1111) break;
      step();
    end
    check("lit_before_reset", 32'(an_a != 4'b1111), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_an_a", 32'(an_a), 32'hF);
    check("async_rst_seg_a", 32'(seg_a), 32'h7F);
    check("async_rst_dp_a", 32'(dp_a), 32'd1);
    check("async_rst_an_b", 32'(an_b), 32'hF);
    check("async_rst_seg_b", 32'(seg_b), 32'h7F);
    q_a.delete();
    q_b.delete();
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(10);
    pulse_load(16'h9081, 4'b1010);
    wait_frame();
    run(20);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It takes a packed vector of BCD digits and drives the shared active-low segment bus and the per-digit active-low anode enables. One digit is lit at a time, with a programmable dead time between digits to suppress ghosting. It sits between application logic that produces BCD values and the display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8).
TICKS_PER_DIGIT, 100000, clk cycles per digit slot, including the blank time (1 ms at 100 MHz).
BLANK_TICKS, 1000, cycles per slot with all anodes off before the digit is lit; 0 means no blank phase; must be < TICKS_PER_DIGIT.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous and active-low.
en  input  1  scan enable; 0 forces the display dark.
digits  input  4*NUM_DIGITS  packed BCD; digit i is bits [4i+3:4i], and digit 0 is the rightmost.
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
load  input  1  single-cycle strobe that captures digits and dp_in into the pending registers.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
AN  output  NUM_DIGITS  anode enables, active-low, one-hot-zero.
frame_done  output  1  one-cycle pulse at the end of the last digit slot of each frame.

Behaviour:
- Reset (rst_n=0, asynchronous): AN all ones, seg=7'b1111111, dp=1, frame_done=0, state=IDLE, digit index=0, tick counter=0, pending and active registers all zero.
- All outputs are registered and change on the same edge as the state and index update.
- Double buffering:
  - load=1 copies digits and dp_in into the pending registers on that edge.
  - Pending is copied to active only on entry to slot 0, i.e. at a frame boundary. Frames are never torn.
  - If load and a frame-boundary transfer fall on the same edge, active takes the old pending value and pending takes the new inputs.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: AN all ones, seg all ones. When en=1, go to BLANK with index=0 and apply pending to active.
  - BLANK: AN all ones, seg all ones. Lasts BLANK_TICKS cycles, then go to SHOW. When BLANK_TICKS=0 the state is skipped and the FSM goes directly to SHOW.
  - SHOW: AN[index]=0 and all other AN bits are 1. seg is the decode of active digit[index]; dp = ~active_dp[index]. Lasts TICKS_PER_DIGIT-BLANK_TICKS cycles.
  - On SHOW exit with index < NUM_DIGITS-1: index+1, go to BLANK.
  - On SHOW exit with index = NUM_DIGITS-1: frame_done=1 for one cycle, index wraps to 0, apply pending, go to BLANK.
- Slot period is exactly TICKS_PER_DIGIT cycles. Frame period is NUM_DIGITS*TICKS_PER_DIGIT cycles.
- en deasserted in any state: on the next edge go to IDLE, AN all ones, seg all ones, dp=1, index=0, counter=0, no frame_done. Pending is retained.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10..15 give all segments off (1111111); dp is still honoured.
- The tick counter width is $clog2(TICKS_PER_DIGIT); it resets to 0 at every state change.

Optional Feature:
Macro LEAD_ZERO_BLANK_EN.
- Defined: each active digit equal to 0, scanning from NUM_DIGITS-1 downward and stopping at the first nonzero digit, shows all segments off. Digit 0 is always displayed. The dp of a blanked digit is still honoured. The AN scan timing is unchanged.
- Not defined: all zeros are displayed as 0.

Decomposition:
- Package ssd_pkg:
  - seg_t (logic [6:0]);
  - SEG_OFF=7'b1111111;
  - localparam array SEG_LUT[0:9];
  - state enum scan_state_e {IDLE, BLANK, SHOW}.
- One sub-module, ssd_seg_decode: combinational 4-bit BCD to seg_t, with the invalid-code blanking. It is instantiated once, on the muxed digit.

Test Plan:
(Bench parameters: NUM_DIGITS=4, TICKS_PER_DIGIT=4, BLANK_TICKS=1.)
1. Reset mid-scan: assert rst_n=0 asynchronously while in SHOW -> AN=4'b1111, seg=7'b1111111, dp=1 immediately, without waiting for a clock edge.
2. Basic scan: load digits=16'h1234, dp_in=4'b0100, en=1 -> per slot, AN is 1111 for 1 cycle then 1110/1101/1011/0111 for 3 cycles each. seg shows 4,3,2,1 in that order. dp=0 only in slot 2. frame_done pulses once every 16 cycles.
3. Frame-boundary load: load 16'h5678 during slot 1 -> slots 1..3 of the current frame still show 3,2,1; the next frame shows 8,7,6,5.
4. Invalid code and en drop: digits=16'h00AF -> slots 0 and 1 show 1111111. Deassert en in slot 2 -> AN=1111 next cycle, no frame_done. Re-enable -> the scan restarts at slot 0.
5. With LEAD_ZERO_BLANK_EN defined, digits=16'h0050:
   - slots 3 and 2 show 1111111;
   - slot 1 shows 0010010 (5);
   - slot 0 shows 1000000 (0).
   Without the macro, slot 3 shows 1000000.
6. BLANK_TICKS=0 variant: AN is never 1111 while en=1 after the first slot, and each digit is lit for 4 cycles.
